// File: rtl/l2_cache.sv
// Set-associative L2 cache: write-through, write-allocate, true-LRU replacement, single-beat block fills.
// Optional hit/miss counters are built when L2_CACHE_STATS_EN is defined.
module l2_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int CACHE_SIZE = 512,
   parameter int BLOCK_SIZE = 32,
   parameter int NUM_WAYS   = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [ADDR_WIDTH-1:0]            l1_cache_addr,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_cache_data_in,
   input  logic                             l1_cache_read,
   input  logic                             l1_cache_write,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_block_data_out,
   output logic                             l1_block_valid,
   output logic                             l1_cache_ready,
   output logic                             l1_cache_hit,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
   input  logic                             mem_ready,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
   output logic                             mem_read,
   output logic                             mem_write
`ifdef L2_CACHE_STATS_EN
   ,
   output logic [15:0]                      hit_count,
   output logic [15:0]                      miss_count
`endif
);

   localparam int BLOCK_W  = BLOCK_SIZE * DATA_WIDTH;
   localparam int NUM_SETS = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
   localparam int IDX_W    = $clog2(NUM_SETS);
   localparam int WAY_W    = $clog2(NUM_WAYS);
   localparam int TAG_W    = ADDR_WIDTH - IDX_W;

   typedef enum logic {IDLE, FILL} state_t;
   typedef logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] age_t;

   state_t state, state_nxt;

   logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid;
   age_t                              age;
   logic [TAG_W-1:0]                  tags   [NUM_SETS][NUM_WAYS];
   logic [BLOCK_W-1:0]                blocks [NUM_SETS][NUM_WAYS];
   logic [ADDR_WIDTH-1:0]             fill_addr;

   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [IDX_W-1:0]      sel_idx;
   logic [TAG_W-1:0]      sel_tag;
   logic                  hit, has_invalid;
   logic [WAY_W-1:0]      hit_way, invalid_way, lru_way, victim_way;
   logic                  do_write, do_rhit, do_rmiss, do_fill, install;
   logic [WAY_W-1:0]      install_way, access_way;
   logic [BLOCK_W-1:0]    install_data;

   // Age 0 is most recently used; reset ordering makes the highest way the first LRU victim.
   function automatic age_t age_init();
      age_t a;
      for (int s = 0; s < NUM_SETS; s++)
         for (int w = 0; w < NUM_WAYS; w++)
            a[s][w] = WAY_W'(w);
      return a;
   endfunction

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= IDLE;
      else       state <= state_nxt;
   end

   // During FILL the lookup works on the latched miss address so the victim is chosen at install time.
   always_comb begin
      sel_addr    = (state == FILL) ? fill_addr : l1_cache_addr;
      sel_idx     = sel_addr[IDX_W-1:0];
      sel_tag     = sel_addr[ADDR_WIDTH-1:IDX_W];
      hit         = 1'b0;
      hit_way     = '0;
      has_invalid = 1'b0;
      invalid_way = '0;
      lru_way     = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid[sel_idx][w] && tags[sel_idx][w] == sel_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (age[sel_idx][w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid[sel_idx][w]) begin
            has_invalid = 1'b1;
            invalid_way = WAY_W'(w);
         end
      end
      victim_way   = has_invalid ? invalid_way : lru_way;
      do_write     = (state == IDLE) && l1_cache_write;
      do_rhit      = (state == IDLE) && l1_cache_read && !l1_cache_write && hit;
      do_rmiss     = (state == IDLE) && l1_cache_read && !l1_cache_write && !hit;
      do_fill      = (state == FILL) && mem_ready;
      install      = do_write || do_fill;
      install_way  = (do_write && hit) ? hit_way : victim_way;
      install_data = do_fill ? mem_data_block : l1_cache_data_in;
      access_way   = do_rhit ? hit_way : install_way;
      state_nxt    = state;
      case (state)
         IDLE:    if (do_rmiss) state_nxt = FILL;
         FILL:    if (do_fill)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         valid <= '0;
         age   <= age_init();
      end else begin
         if (install) valid[sel_idx][install_way] <= 1'b1;
         if (do_write || do_rhit || do_fill) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (WAY_W'(w) == access_way)
                  age[sel_idx][w] <= '0;
               else if (age[sel_idx][w] < age[sel_idx][access_way])
                  age[sel_idx][w] <= age[sel_idx][w] + WAY_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (install) begin
         tags[sel_idx][install_way]   <= sel_tag;
         blocks[sel_idx][install_way] <= install_data;
      end
      if (do_rmiss) fill_addr <= l1_cache_addr;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         l1_block_data_out <= '0;
         l1_block_valid    <= 1'b0;
         l1_cache_ready    <= 1'b0;
         l1_cache_hit      <= 1'b0;
         mem_addr          <= '0;
         mem_data_out      <= '0;
         mem_read          <= 1'b0;
         mem_write         <= 1'b0;
      end else begin
         l1_block_valid <= 1'b0;
         l1_cache_ready <= 1'b0;
         mem_write      <= 1'b0;
         if (do_write) begin
            mem_write      <= 1'b1;
            mem_addr       <= l1_cache_addr;
            mem_data_out   <= l1_cache_data_in;
            l1_cache_ready <= 1'b1;
            l1_cache_hit   <= hit;
         end else if (do_rhit) begin
            l1_block_data_out <= blocks[sel_idx][hit_way];
            l1_block_valid    <= 1'b1;
            l1_cache_ready    <= 1'b1;
            l1_cache_hit      <= 1'b1;
         end else if (do_rmiss) begin
            mem_read <= 1'b1;
            mem_addr <= l1_cache_addr;
         end else if (do_fill) begin
            l1_block_data_out <= mem_data_block;
            l1_block_valid    <= 1'b1;
            l1_cache_ready    <= 1'b1;
            l1_cache_hit      <= 1'b0;
            mem_read          <= 1'b0;
         end
      end
   end

`ifdef L2_CACHE_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (do_rhit || (do_write && hit))    hit_count  <= sat_inc(hit_count);
         if (do_fill || (do_write && !hit))   miss_count <= sat_inc(miss_count);
      end
   end
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Scoreboard bench for l2_cache: request tasks push expected completions, a negedge monitor pops and compares.
module tb_l2_cache;

   localparam int DW = 32;
   localparam int AW = 11;
   localparam int BS = 32;
   localparam int BW = BS * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] l1_cache_addr;
   logic [BW-1:0] l1_cache_data_in;
   logic          l1_cache_read;
   logic          l1_cache_write;
   logic [BW-1:0] l1_block_data_out;
   logic          l1_block_valid;
   logic          l1_cache_ready;
   logic          l1_cache_hit;
   logic [BW-1:0] mem_data_block;
   logic          mem_ready;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_data_out;
   logic          mem_read;
   logic          mem_write;
`ifdef L2_CACHE_STATS_EN
   logic [15:0]   hit_count;
   logic [15:0]   miss_count;
`endif

   l2_cache dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .l1_cache_addr     (l1_cache_addr),
      .l1_cache_data_in  (l1_cache_data_in),
      .l1_cache_read     (l1_cache_read),
      .l1_cache_write    (l1_cache_write),
      .l1_block_data_out (l1_block_data_out),
      .l1_block_valid    (l1_block_valid),
      .l1_cache_ready    (l1_cache_ready),
      .l1_cache_hit      (l1_cache_hit),
      .mem_data_block    (mem_data_block),
      .mem_ready         (mem_ready),
      .mem_addr          (mem_addr),
      .mem_data_out      (mem_data_out),
      .mem_read          (mem_read),
      .mem_write         (mem_write)
`ifdef L2_CACHE_STATS_EN
      ,
      .hit_count         (hit_count),
      .miss_count        (miss_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          hit;
      bit          valid;
      bit          mw;
      logic [31:0] w0;
      logic [31:0] w31;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model[int];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          hits_exp = 0;
   int          misses_exp = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [BW-1:0] mk_block(input logic [31:0] base);
      logic [BW-1:0] blk;
      for (int i = 0; i < BS; i++) blk[i*DW +: DW] = base ^ 32'(i);
      return blk;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n && l1_cache_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("hit", 32'(l1_cache_hit), 32'(e.hit));
            check("blk_valid", 32'(l1_block_valid), 32'(e.valid));
            check("mem_write", 32'(mem_write), 32'(e.mw));
            if (e.valid) begin
               check("rd_w0", l1_block_data_out[31:0], e.w0);
               check("rd_w31", l1_block_data_out[BW-1 -: 32], e.w31);
            end
            if (e.mw) begin
               check("wr_w0", mem_data_out[31:0], e.w0);
               check("wr_w31", mem_data_out[BW-1 -: 32], e.w31);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      hits_exp   = 0;
      misses_exp = 0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input bit exp_hit, input logic [31:0] fill_base, input int lat);
      exp_t        e;
      logic [31:0] b;
      b = exp_hit ? model[int'(a)] : fill_base;
      e = '{hit: exp_hit, valid: 1'b1, mw: 1'b0, w0: b, w31: b ^ 32'd31};
      @(negedge clk);
      l1_cache_addr = a;
      l1_cache_read = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1 l1_cache_read = 1'b0;
      if (!exp_hit) begin
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("mem_read_held", 32'(mem_read), 32'd1);
            check("mem_addr_rd", 32'(mem_addr), 32'(a));
         end
         mem_data_block = mk_block(fill_base);
         mem_ready      = 1'b1;
         @(posedge clk);
         #1 mem_ready = 1'b0;
         @(negedge clk);
         check("mem_read_drop", 32'(mem_read), 32'd0);
         model[int'(a)] = fill_base;
         misses_exp++;
      end else begin
         @(negedge clk);
         hits_exp++;
      end
      @(negedge clk);
      check("ready_pulse", 32'(l1_cache_ready), 32'd0);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] base, input bit exp_hit, input bit also_read);
      exp_t e;
      e = '{hit: exp_hit, valid: 1'b0, mw: 1'b1, w0: base, w31: base ^ 32'd31};
      @(negedge clk);
      l1_cache_addr    = a;
      l1_cache_data_in = mk_block(base);
      l1_cache_write   = 1'b1;
      l1_cache_read    = also_read;
      sb.push_back(e);
      @(posedge clk);
      #1;
      l1_cache_write = 1'b0;
      l1_cache_read  = 1'b0;
      @(negedge clk);
      check("mem_addr_wr", 32'(mem_addr), 32'(a));
      check("mem_read_wr", 32'(mem_read), 32'd0);
      model[int'(a)] = base;
      if (exp_hit) hits_exp++;
      else         misses_exp++;
      @(negedge clk);
      check("ready_pulse", 32'(l1_cache_ready), 32'd0);
      check("mem_write_pulse", 32'(mem_write), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n            = 1'b1;
      l1_cache_addr    = '0;
      l1_cache_data_in = '0;
      l1_cache_read    = 1'b0;
      l1_cache_write   = 1'b0;
      mem_data_block   = '0;
      mem_ready        = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(l1_cache_ready), 32'd0);
      check("rst_valid", 32'(l1_block_valid), 32'd0);
      check("rst_hit", 32'(l1_cache_hit), 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_data", mem_data_out[31:0], 32'd0);
      check("rst_blk_out", l1_block_data_out[31:0], 32'd0);
      rst_n = 1'b0;

      do_read(11'h00A, 1'b0, 32'hDEADBEEF, 2);
      do_read(11'h00A, 1'b1, 32'h0, 0);
      do_write(11'h014, 32'hA5A5A5A5, 1'b0, 1'b0);
      do_write(11'h014, 32'h5A5A5A5A, 1'b1, 1'b0);
      do_read(11'h014, 1'b1, 32'h0, 0);

      // mem_ready outside FILL must not complete anything
      @(negedge clk);
      mem_data_block = mk_block(32'hBAD0BAD0);
      mem_ready      = 1'b1;
      @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      check("idle_mem_ready", 32'(l1_cache_ready), 32'd0);
      check("idle_mem_valid", 32'(l1_block_valid), 32'd0);
      do_read(11'h00A, 1'b1, 32'h0, 0);

      // read and write together: only the write completes
      do_write(11'h00A, 32'h11110000, 1'b1, 1'b1);
      do_read(11'h00A, 1'b1, 32'h0, 0);
`ifdef L2_CACHE_STATS_EN
      check("hit_count", 32'(hit_count), 32'(hits_exp));
      check("miss_count", 32'(miss_count), 32'(misses_exp));
`endif

      // LRU: four fills occupy set 0, the fifth evicts 0x000
      do_reset();
      do_read(11'h000, 1'b0, 32'h00001000, 1);
      do_read(11'h004, 1'b0, 32'h00001004, 1);
      do_read(11'h008, 1'b0, 32'h00001008, 1);
      do_read(11'h00C, 1'b0, 32'h0000100C, 1);
      do_read(11'h010, 1'b0, 32'h00001010, 3);
      do_read(11'h004, 1'b1, 32'h0, 0);
      do_read(11'h000, 1'b0, 32'h00002000, 1);

      // reset in the middle of a fill
      @(negedge clk);
      l1_cache_addr = 11'h020;
      l1_cache_read = 1'b1;
      @(posedge clk);
      #1 l1_cache_read = 1'b0;
      @(negedge clk);
      check("abort_mem_read_up", 32'(mem_read), 32'd1);
      #1 rst_n = 1'b1;
      #1 check("abort_mem_read_drop", 32'(mem_read), 32'd0);
      @(negedge clk);
      rst_n      = 1'b0;
      hits_exp   = 0;
      misses_exp = 0;
      do_read(11'h020, 1'b0, 32'h00003020, 1);
`ifdef L2_CACHE_STATS_EN
      check("hit_count_post", 32'(hit_count), 32'(hits_exp));
      check("miss_count_post", 32'(miss_count), 32'(misses_exp));
`endif

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/l2_cache.md
L2_CACHE -- requirements
Module: l2_cache

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32: bits per word.
- ADDR_WIDTH, default 11: block-address width.
- CACHE_SIZE, default 512: total capacity in words.
- BLOCK_SIZE, default 32: words per block.
- NUM_WAYS, default 4: associativity.
REQ-002 Ports SHALL be (a block bus is BLOCK_SIZE x DATA_WIDTH, packed, word 0 least significant):
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-HIGH reset (codebase port name kept; 1 = reset asserted).
- l1_cache_addr  in  ADDR_WIDTH  block address.
- l1_cache_data_in  in  block  write block.
- l1_cache_read  in  1  read request.
- l1_cache_write  in  1  write request.
- l1_block_data_out  out  block  read data.
- l1_block_valid  out  1  l1_block_data_out valid.
- l1_cache_ready  out  1  request complete.
- l1_cache_hit  out  1  completed request hit.
- mem_data_block  in  block  fill data from memory.
- mem_ready  in  1  fill data valid.
- mem_addr  out  ADDR_WIDTH  memory block address.
- mem_data_out  out  block  write-through data.
- mem_read  out  1  fill request.
- mem_write  out  1  write-through strobe.

Function
REQ-003 Geometry SHALL be NUM_SETS = CACHE_SIZE/(BLOCK_SIZE*NUM_WAYS), which is 4 at the defaults; index = addr[log2(NUM_SETS)-1:0]; tag = the remaining upper address bits; each way SHALL store a valid bit, a tag and a block.
REQ-004 The controller SHALL be an FSM with two states, IDLE and FILL; requests SHALL be sampled only in IDLE and ignored in FILL.
REQ-005 Outputs SHALL be registered. l1_cache_ready, l1_block_valid and mem_write SHALL be one-cycle pulses. l1_cache_hit SHALL be meaningful only while l1_cache_ready=1 and SHALL hold its value until the next completion.
REQ-006 Read hit, sampled in IDLE: on the same edge, load the hit block into l1_block_data_out and pulse l1_block_valid=1, l1_cache_ready=1 with l1_cache_hit=1; update LRU; one-cycle latency.
REQ-007 Read miss: on the sampling edge, set mem_read=1 and mem_addr=addr, latch addr, and go to FILL; mem_read SHALL stay high until mem_ready is sampled.
REQ-008 In FILL, on the edge where mem_ready=1:
- install mem_data_block into the victim way with valid=1 and the new tag;
- drive that block on l1_block_data_out;
- pulse l1_block_valid=1 and l1_cache_ready=1 with l1_cache_hit=0;
- clear mem_read, update LRU, and return to IDLE.
REQ-009 Writes SHALL be write-through and write-allocate. On the sampling edge, for both hit and miss:
- write l1_cache_data_in into the hit way, or into the victim way on a miss, setting valid and tag;
- pulse mem_write=1 with mem_addr=addr and mem_data_out=l1_cache_data_in;
- pulse l1_cache_ready=1 with l1_cache_hit equal to the hit result; l1_block_valid SHALL stay 0.
REQ-010 A write SHALL complete in one cycle; memory SHALL accept mem_write without handshake, and mem_ready SHALL be ignored outside FILL.
REQ-011 Victim selection SHALL take the lowest-numbered invalid way first; otherwise the true-LRU way, using per-way age counters of log2(NUM_WAYS) bits per set. No dirty state exists, so eviction SHALL discard the victim.
REQ-012 If read and write are asserted together, the write SHALL take priority and the read SHALL be dropped.
REQ-013 A tag compare SHALL require valid=1; at most one way can match.

Reset
REQ-014 While rst_n=1, asynchronously:
- all valid bits=0, LRU ages=way index, FSM=IDLE;
- mem_read, mem_write, l1_cache_ready, l1_block_valid, l1_cache_hit=0;
- mem_addr, mem_data_out, l1_block_data_out=0.
REQ-015 Reset asserted during FILL SHALL abandon the fill, and no line SHALL be installed.

Configuration
REQ-016 With macro L2_CACHE_STATS_EN defined, the block SHALL add two outputs, hit_count and miss_count, each 16 bits:
- both reset to 0;
- each increments once per completed request of its kind;
- each saturates at 0xFFFF.
REQ-017 Without L2_CACHE_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-018 Read miss at addr 0x00A: one cycle after sampling, mem_read=1 and mem_addr=0x00A; with mem_data_block[i]=0xDEADBEEF^i and mem_ready=1 for one edge, the outputs SHALL be valid=1, ready=1, hit=0, and mem_read SHALL drop.
REQ-019 Read of 0x00A again: after one edge, valid=1, ready=1, hit=1 and l1_block_data_out[0]=0xDEADBEEF.
REQ-020 Write miss at 0x014 with data[i]=0xA5A5A5A5^i: after one edge, mem_write=1, mem_data_out[0]=0xA5A5A5A5, ready=1, hit=0.
REQ-021 Write at 0x014 with data[i]=0x5A5A5A5A^i: after one edge, mem_write=1, ready=1, hit=1; a subsequent read of 0x014 SHALL hit and return word0=0x5A5A5A5A.
REQ-022 LRU check: fill five distinct tags into set 0 (addrs 0x000, 0x004, 0x008, 0x00C, 0x010); 0x000 SHALL be evicted, so a read of 0x000 misses and a read of 0x004 hits.
REQ-023 Assert reset mid-FILL: mem_read SHALL drop immediately, and a read of the same address afterwards SHALL miss.
